// File: rtl/rca_pkg.sv
// rca_pkg: shared constants and the arithmetic reference for the ripple-carry adder.
// rca_ref_sum returns {cout, sum} for an adder of the given width.
// Operand bits at or above that width are ignored.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 8;
    localparam int RCA_REF_MAX_WIDTH = 64;

    // Plain-arithmetic reference: (a + b + cin) mod 2^(width+1), with operands truncated to width.
    function automatic logic [RCA_REF_MAX_WIDTH:0] rca_ref_sum(
        input logic [RCA_REF_MAX_WIDTH-1:0] a,
        input logic [RCA_REF_MAX_WIDTH-1:0] b,
        input logic                         cin,
        input int                           width = RCA_DEFAULT_WIDTH
    );
        logic [RCA_REF_MAX_WIDTH-1:0] a_m;
        logic [RCA_REF_MAX_WIDTH-1:0] b_m;
        logic [RCA_REF_MAX_WIDTH:0]   full;
        a_m = a;
        b_m = b;
        for (int i = 0; i < RCA_REF_MAX_WIDTH; i++) begin
            if (i >= width) begin
                a_m[i] = 1'b0;
                b_m[i] = 1'b0;
            end
        end
        full = {1'b0, a_m} + {1'b0, b_m} + {{RCA_REF_MAX_WIDTH{1'b0}}, cin};
        return full;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: one combinational bit cell of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term feeds both the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder_reg.sv
// ripple_carry_adder_reg: WIDTH-bit ripple-carry adder with registered sum, carry-out and valid.
// Build option RCA_INPUT_REG_EN adds an input register stage ahead of the chain.
// Latency is 1 cycle without it and 2 cycles with it; throughput is 1 result per cycle in both builds.
module ripple_carry_adder_reg
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] a_core;
    logic [WIDTH-1:0] b_core;
    logic             cin_core;
    logic             in_valid_core;

`ifdef RCA_INPUT_REG_EN
    logic [WIDTH-1:0] a_in_q, a_in_d;
    logic [WIDTH-1:0] b_in_q, b_in_d;
    logic             cin_in_q, cin_in_d;
    logic             in_valid_in_q, in_valid_in_d;

    // Operands load only on valid beats; idle (possibly X) operands never reach the chain.
    always_comb begin
        a_in_d        = a_in_q;
        b_in_d        = b_in_q;
        cin_in_d      = cin_in_q;
        in_valid_in_d = in_valid;
        if (in_valid) begin
            a_in_d   = a;
            b_in_d   = b;
            cin_in_d = cin;
        end
    end

    // Input stage registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_in_q        <= '0;
            b_in_q        <= '0;
            cin_in_q      <= 1'b0;
            in_valid_in_q <= 1'b0;
        end else begin
            a_in_q        <= a_in_d;
            b_in_q        <= b_in_d;
            cin_in_q      <= cin_in_d;
            in_valid_in_q <= in_valid_in_d;
        end
    end

    assign a_core        = a_in_q;
    assign b_core        = b_in_q;
    assign cin_core      = cin_in_q;
    assign in_valid_core = in_valid_in_q;
`else
    assign a_core        = a;
    assign b_core        = b;
    assign cin_core      = cin;
    assign in_valid_core = in_valid;
`endif

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin_core;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_core[i]),
            .b    (b_core[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    // Load the chain result on a valid beat; otherwise hold the result and drop valid.
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = in_valid_core;
        if (in_valid_core) begin
            s_d    = sum_comb;
            cout_d = carry[WIDTH];
        end
    end

    // Output registers; reset discards any in-flight result immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Bench for ripple_carry_adder_reg: an 8-bit and a 4-bit instance share one stimulus stream.
// It honours RCA_INPUT_REG_EN for the expected latency.
module tb_ripple_carry_adder_reg;
    import rca_pkg::*;

`ifdef RCA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a, b;
    logic       cin;

    logic       ov8, co8;
    logic [7:0] s8;
    logic       ov4, co4;
    logic [3:0] s4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(ov8), .s(s8), .cout(co8)
    );

    ripple_carry_adder_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .out_valid(ov4), .s(s4), .cout(co4)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: results appear LAT edges after a valid beat; idle beats hold the result and clear valid.
    logic       tap_v;
    logic [7:0] tap_a, tap_b;
    logic       tap_c;
    logic       exp_v;
    logic [8:0] exp8;
    logic [4:0] exp4;

`ifdef RCA_INPUT_REG_EN
    logic       m_v;
    logic [7:0] m_a, m_b;
    logic       m_c;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= 1'b0; m_a <= '0; m_b <= '0; m_c <= 1'b0;
        end else begin
            m_v <= in_valid; m_a <= a; m_b <= b; m_c <= cin;
        end
    end
    assign tap_v = m_v;
    assign tap_a = m_a;
    assign tap_b = m_b;
    assign tap_c = m_c;
`else
    assign tap_v = in_valid;
    assign tap_a = a;
    assign tap_b = b;
    assign tap_c = cin;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_v <= 1'b0;
            exp8  <= '0;
            exp4  <= '0;
        end else begin
            exp_v <= tap_v;
            if (tap_v) begin
                exp8 <= 9'(rca_ref_sum(64'(tap_a), 64'(tap_b), tap_c, 8));
                exp4 <= 5'(rca_ref_sum(64'(tap_a), 64'(tap_b), tap_c, 4));
            end
        end
    end

    // Cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        check("w8_cycle", 64'({ov8, co8, s8}), 64'({exp_v, exp8}));
        check("w4_cycle", 64'({ov4, co4, s4}), 64'({exp_v, exp4}));
    end

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'hxx, 8'hxx, 1'bx);
    endtask

    logic [7:0] bb_a [0:2];
    logic [7:0] bb_b [0:2];
    logic       bb_c [0:2];
    logic [9:0] bb_e [0:2];

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_w8", 64'({ov8, co8, s8}), 64'(10'h000));
        check("reset_w4", 64'({ov4, co4, s4}), 64'(6'h00));

        check("ref_12_34_0", rca_ref_sum(64'h12, 64'h34, 1'b0, 8), 65'h046);
        check("ref_ff_00_1", rca_ref_sum(64'hFF, 64'h00, 1'b1, 8), 65'h100);
        check("ref_ff_ff_1", rca_ref_sum(64'hFF, 64'hFF, 1'b1, 8), 65'h1FF);
        check("ref_w4_f_f_1", rca_ref_sum(64'hFF, 64'h0F, 1'b1, 4), 65'h1F);

        rst = 1'b0;
        idle(1);
        check("post_release_idle", 64'({ov8, co8, s8}), 64'(10'h000));

        drive(1'b1, 8'h12, 8'h34, 1'b0);
        idle(LAT - 1);
        check("basic_add", 64'({ov8, co8, s8}), 64'({1'b1, 1'b0, 8'h46}));

        // Asynchronous reset between edges while a result is valid.
        #2 rst = 1'b1;
        #1 check("async_reset", 64'({ov8, co8, s8}), 64'(10'h000));
        check("async_reset_w4", 64'({ov4, co4, s4}), 64'(6'h00));
        @(negedge clk);
        check("reset_held", 64'({ov8, co8, s8}), 64'(10'h000));
        rst = 1'b0;

        // First edge after release accepts a valid beat.
        drive(1'b1, 8'hFF, 8'h00, 1'b1);
        idle(LAT - 1);
        check("carry_ff_00_1", 64'({ov8, co8, s8}), 64'({1'b1, 1'b1, 8'h00}));
        check("carry_w4_f_0_1", 64'({ov4, co4, s4}), 64'({1'b1, 1'b1, 4'h0}));

        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        idle(LAT - 1);
        check("carry_ff_ff_1", 64'({ov8, co8, s8}), 64'({1'b1, 1'b1, 8'hFF}));

        bb_a[0] = 8'h01; bb_b[0] = 8'h01; bb_c[0] = 1'b0; bb_e[0] = {1'b1, 1'b0, 8'h02};
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_c[1] = 1'b0; bb_e[1] = {1'b1, 1'b1, 8'h00};
        bb_a[2] = 8'h7F; bb_b[2] = 8'h01; bb_c[2] = 1'b1; bb_e[2] = {1'b1, 1'b0, 8'h81};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1'b1, bb_a[i], bb_b[i], bb_c[i]);
            else       idle(1);
            if (i - (LAT - 1) >= 0 && i - (LAT - 1) <= 2)
                check($sformatf("b2b_%0d", i - (LAT - 1)), 64'({ov8, co8, s8}), 64'(bb_e[i - (LAT - 1)]));
            else if (i - (LAT - 1) >= 3)
                check($sformatf("idle_hold_%0d", i), 64'({ov8, co8, s8}), 64'({1'b0, 1'b0, 8'h81}));
        end

        // Exhaustive for the 4-bit instance; upper operand bits are random for the 8-bit one.
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    drive(1'b1, {4'($urandom), 4'(ai)}, {4'($urandom), 4'(bi)}, 1'(ci));
        idle(2);

        // Random traffic with occasional idle beats carrying X operands.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) != 0) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            else                           idle(1);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
